// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FPmul result buffer.
package fpmul_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    STALL  = 2'd3
  } fpmul_buf_state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
  } fpmul_flags_t;

  // IEEE-754 single-precision class of a result word.
  function automatic fpmul_flags_t fp_classify(input logic [FP_W-1:0] z);
    fpmul_flags_t f;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = &z[30:23];
    exp_zero = ~|z[30:23];
    man_zero = ~|z[22:0];
    f.nan    = exp_ones & ~man_zero;
    f.inf    = exp_ones & man_zero;
    f.zero   = exp_zero & man_zero;
    f.denorm = exp_zero & ~man_zero;
    return f;
  endfunction

endpackage

// File: rtl/fpmul_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module fpmul_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_rd;

  // A read on an empty FIFO is dropped; pointers wrap naturally at power-of-2 depth.
  always_comb begin
    do_rd    = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en_i && !do_rd)      count_d = count_q + CNT_W'(1);
    else if (!wr_en_i && do_rd) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en_i && (count_q == CNT_W'(DEPTH))))
    else $error("fpmul_sync_fifo: write while full");

endmodule

// File: rtl/fpmul_out_buffer.sv
// Credit-based result buffer behind a fixed-latency FPmul pipeline.
// Optional per-entry class flags on out_flags when FPMUL_OUT_FLAGS_EN is defined.
module fpmul_out_buffer import fpmul_pkg::*; #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_W-1:0]     mul_z,
  output logic [FP_W-1:0]     out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output fpmul_buf_state_t    state
`ifdef FPMUL_OUT_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0]  out_flags
`endif
);

  localparam int unsigned CRD_W = $clog2(DEPTH+1);
`ifdef FPMUL_OUT_FLAGS_EN
  localparam int unsigned ENT_W = FP_W + FLAGS_W;
`else
  localparam int unsigned ENT_W = FP_W;
`endif

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CRD_W-1:0]   crd_q, crd_d;
  logic [CRD_W-1:0]   fifo_cnt;
  logic [ENT_W-1:0]   wr_entry, rd_entry;
  logic               issue, pop, wr_en;

  assign in_ready  = (crd_q != '0);
  assign out_valid = (fifo_cnt != '0);
  assign issue     = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = vld_q[LATENCY-1];

  // In-flight tracker mirrors the FPmul pipeline; it never stalls.
  if (LATENCY == 1) begin : g_lat1
    assign vld_d = issue;
  end else begin : g_latn
    assign vld_d = {vld_q[LATENCY-2:0], issue};
  end

  always_comb begin
    crd_d = crd_q;
    if (issue && !pop)      crd_d = crd_q - CRD_W'(1);
    else if (pop && !issue) crd_d = crd_q + CRD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      crd_q <= CRD_W'(DEPTH);
    end else begin
      vld_q <= vld_d;
      crd_q <= crd_d;
    end
  end

  always_comb begin
    state = FILL;
    if (crd_q == CRD_W'(DEPTH)) state = EMPTY;
    else if (crd_q == '0)       state = STALL;
    else if (fifo_cnt != '0)    state = STREAM;
  end

`ifdef FPMUL_OUT_FLAGS_EN
  assign wr_entry  = {fp_classify(mul_z), mul_z};
  assign out_flags = out_valid ? rd_entry[ENT_W-1:FP_W] : '0;
`else
  assign wr_entry  = mul_z;
`endif
  assign out_data  = rd_entry[FP_W-1:0];

  fpmul_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .count_o   (fifo_cnt)
  );

endmodule

// File: tb/tb_fpmul_out_buffer.sv
// Randomized bench for fpmul_out_buffer with a queue-based reference model.
module tb_fpmul_out_buffer;
  import fpmul_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      mul_z;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  fpmul_buf_state_t state;
`ifdef FPMUL_OUT_FLAGS_EN
  logic [3:0]       out_flags;
`endif

  always #5 clk = ~clk;

  fpmul_out_buffer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_z     (mul_z),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state     (state)
`ifdef FPMUL_OUT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          m_credits;
  logic [31:0] m_q[$];
  logic [31:0] m_due[int];
  logic [31:0] z_drv[int];
  logic [31:0] vals[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic logic [1:0] exp_state();
    if (m_credits == int'(DEP)) return 2'(EMPTY);
    if (m_credits == 0)         return 2'(STALL);
    if (m_q.size() != 0)        return 2'(STREAM);
    return 2'(FILL);
  endfunction

`ifdef FPMUL_OUT_FLAGS_EN
  function automatic logic [3:0] cls(input logic [31:0] z);
    int e;
    bit mz;
    e  = int'(z[30:23]);
    mz = (z[22:0] == 23'd0);
    return {e == 255 && !mz, e == 255 && mz, e == 0 && mz, e == 0 && !mz};
  endfunction
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_credits != 0));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("state", 32'(state), 32'(exp_state()));
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
`ifdef FPMUL_OUT_FLAGS_EN
      chk("out_flags", 32'(out_flags), (m_q.size() != 0) ? 32'(cls(m_q[0])) : 32'd0);
`endif
    end
  end

  // Drive one edge's inputs, predict the post-edge state, then settle past the next negedge.
  task automatic step(input bit iv, input bit ordy, input bit r, input logic [31:0] res);
    bit iss;
    bit pp;
    in_valid  = iv;
    out_ready = ordy;
    rst       = r;
    if (z_drv.exists(cyc)) begin
      mul_z = z_drv[cyc];
      z_drv.delete(cyc);
    end else begin
      mul_z = $urandom();
    end
    if (r) begin
      m_q.delete();
      m_due.delete();
      m_credits = int'(DEP);
    end else begin
      iss = iv && (m_credits != 0);
      pp  = ordy && (m_q.size() != 0);
      if (pp) void'(m_q.pop_front());
      if (m_due.exists(cyc)) begin
        m_q.push_back(m_due[cyc]);
        m_due.delete(cyc);
      end
      if (iss) begin
        m_due[cyc + int'(LAT)] = res;
        z_drv[cyc + int'(LAT)] = res;
      end
      m_credits = m_credits - int'(iss) + int'(pp);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    mul_z     = '0;
    m_credits = int'(DEP);
    @(negedge clk);
    #1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_state", 32'(state), 32'(EMPTY));

    // Single issue: 1.5 * 2.0 = 3.0 appears exactly LAT edges later.
    step(1, 0, 0, 32'h4040_0000);
    chk("single_fill", 32'(state), 32'(FILL));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("single_early", 32'(out_valid), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h4040_0000);
    step(0, 1, 0, 0);
    chk("single_empty", 32'(state), 32'(EMPTY));

    // Back-pressure: fill all credits, then drain in order on consecutive cycles.
    vals[0] = 32'hA000_0001; vals[1] = 32'hA000_0002;
    vals[2] = 32'hA000_0003; vals[3] = 32'hA000_0004;
    for (int i = 0; i < 4; i++) step(1, 0, 0, vals[i]);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_stall", 32'(state), 32'(STALL));
    repeat (4) step(1, 0, 0, 32'hBAD0_0000);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", out_data, vals[i]);
      step(0, 1, 0, 0);
    end
    chk("bp_empty", 32'(state), 32'(EMPTY));

    // Simultaneous issue and pop with one credit left.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'hC000_0000 + 32'(i));
    repeat (4) step(0, 0, 0, 0);
    step(1, 1, 0, 32'hC000_0003);
    chk("sim_in_ready", 32'(in_ready), 32'd1);
    chk("sim_state", 32'(state), 32'(STREAM));
    repeat (8) step(0, 1, 0, 0);
    chk("sim_drained", 32'(state), 32'(EMPTY));

    // Reset with two results in flight; their late mul_z must be dropped.
    step(1, 0, 0, 32'hDEAD_0001);
    step(1, 0, 0, 32'hDEAD_0002);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_state", 32'(state), 32'(EMPTY));
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'hE000_0000 + 32'(i));
    chk("rst_credit3", 32'(in_ready), 32'd1);
    step(1, 0, 0, 32'hE000_0003);
    chk("rst_credit4", 32'(in_ready), 32'd0);
    repeat (10) step(0, 1, 0, 0);

`ifdef FPMUL_OUT_FLAGS_EN
    step(1, 0, 0, 32'h7FC0_0000);
    step(1, 0, 0, 32'h0000_0000);
    step(1, 0, 0, 32'h0000_0001);
    repeat (4) step(0, 0, 0, 0);
    chk("flags_nan", 32'(out_flags), 32'h8);
    step(0, 1, 0, 0);
    chk("flags_zero", 32'(out_flags), 32'h2);
    step(0, 1, 0, 0);
    chk("flags_denorm", 32'(out_flags), 32'h1);
    repeat (4) step(0, 1, 0, 0);
`endif

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 199) == 0), $urandom());
    end
    repeat (12) step(0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpmul_out_buffer.md
FPMUL_OUT_BUFFER -- requirements
Module: fpmul_out_buffer

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the fixed FPmul pipeline depth in cycles (range 1..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of result FIFO entries (power of 2, range 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning upstream issues an operand pair to FPmul this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning a result slot is reserved and an issue may be accepted.
REQ-007 SHALL have port mul_z, input, 32, the FPmul FP_Z output.
REQ-008 SHALL have port out_data, output, 32, the head-of-FIFO result.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds a stored result.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream consumes out_data this cycle.
REQ-011 SHALL have port state, output, 2, the buffer status (type fpmul_buf_state_t).
REQ-012 SHALL have port out_flags, output, 4, the class of out_data as {nan, inf, zero, denorm}; present only with FPMUL_OUT_FLAGS_EN.

Function
REQ-013 SHALL define an issue as in_valid && in_ready sampled on a rising edge.
REQ-014 SHALL track issues in a LATENCY-bit valid shift register advancing every cycle, never stalled.
REQ-015 SHALL write mul_z into the FIFO on the edge where the shift register's last stage is set; issue at edge k gives write at edge k+LATENCY.
REQ-016 SHALL drive out_valid = (count != 0), with out_data = head entry (first-word fall-through), valid from edge k+LATENCY onward.
REQ-017 SHALL pop the head on out_valid && out_ready; results leave strictly in issue order.
REQ-018 SHALL hold a credit counter, initialised to DEPTH: decrement on issue, increment on pop, unchanged on simultaneous issue and pop.
REQ-019 SHALL drive in_ready = (credits != 0), combinationally from registered credits only.
REQ-020 SHALL decode state from registers: EMPTY when credits==DEPTH; STALL when credits==0; STREAM when count!=0 and credits!=0; otherwise FILL.
REQ-021 SHALL support simultaneous FIFO write and pop in one cycle, including with count==0 (read returns the old head only if count!=0).
REQ-022 SHALL guarantee no write when count==DEPTH; a simulation assertion SHALL fire if it occurs.
REQ-023 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-024 SHALL ignore out_ready when out_valid is low and in_valid when in_ready is low.

Reset
REQ-025 SHALL, on rst, clear the shift register, pointers and count, set credits to DEPTH, and hence in_ready=1, out_valid=0, state=EMPTY, out_flags=0.
REQ-026 SHALL discard results in flight at reset; mul_z arriving after reset for pre-reset issues SHALL NOT be stored.
REQ-027 SHALL not reset FIFO storage; out_data is don't-care while out_valid=0.

Configuration
REQ-028 SHALL, with FPMUL_OUT_FLAGS_EN defined, store a 4-bit class per entry computed from mul_z on write and drive out_flags with the head.
REQ-029 SHALL, without FPMUL_OUT_FLAGS_EN, omit out_flags and its storage entirely; all other behaviour identical.

Structure
REQ-030 SHALL place FP_W=32, fpmul_buf_state_t {EMPTY, FILL, STREAM, STALL} and the flags struct in package fpmul_pkg.
REQ-031 SHALL implement storage as sub-module fpmul_sync_fifo (parameterised width/depth, FWFT, count output).

Verification
REQ-032 SHALL cover single issue: A=0x3FC00000, B=0x40000000 issued at edge k, LATENCY=4 -> out_data=0x40400000, out_valid=1 from edge k+4.
REQ-033 SHALL cover back-pressure: 4 back-to-back issues, out_ready=0 -> in_ready=0 and state=STALL after 4th; then out_ready=1 -> 4 results in issue order on 4 consecutive cycles, state returns to EMPTY.
REQ-034 SHALL cover simultaneous event: credits=1, issue and pop on same edge -> credits stays 1, in_ready stays 1.
REQ-035 SHALL cover reset mid-operation: 2 issues in flight, rst pulsed one cycle -> out_valid=0, credits=4, state=EMPTY, late mul_z never appears on out_data.
REQ-036 SHALL cover flags (FPMUL_OUT_FLAGS_EN): mul_z=0x7FC00000 -> out_flags=4'b1000; mul_z=0x00000000 -> 4'b0010; mul_z=0x00000001 -> 4'b0001.
